// File: rtl/gol_pkg.sv
// Shared constants, FSM state encoding and cell-index helper for the Life engine.
package gol_pkg;

    localparam int unsigned GRID_WIDTH  = 10;
    localparam int unsigned GRID_HEIGHT = 10;
    localparam int unsigned VGA_WIDTH   = 160;
    localparam int unsigned VGA_HEIGHT  = 120;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } gol_state_e;

    function automatic int unsigned cell_idx(input int unsigned x, input int unsigned y,
                                             input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/gol_generation_engine_if.sv
// Control/status bundle between the Life engine and its cursor/tick/display neighbours.
interface gol_generation_engine_if #(
    parameter int unsigned GRID_WIDTH  = gol_pkg::GRID_WIDTH,
    parameter int unsigned GRID_HEIGHT = gol_pkg::GRID_HEIGHT,
    parameter int unsigned GEN_W       = 16
);
    logic                              step_req;
    logic                              clear;
    logic                              edit_en;
    logic [15:0]                       edit_x;
    logic [15:0]                       edit_y;
    logic                              edit_val;
    logic [GRID_WIDTH*GRID_HEIGHT-1:0] cells;
    logic                              busy;
    logic                              done;
    logic                              edit_drop;
    logic [GEN_W-1:0]                  generation;

    modport master (
        output step_req, clear, edit_en, edit_x, edit_y, edit_val,
        input  cells, busy, done, edit_drop, generation
    );

    modport slave (
        input  step_req, clear, edit_en, edit_x, edit_y, edit_val,
        output cells, busy, done, edit_drop, generation
    );
endinterface

// File: rtl/gol_cell_rule.sv
// Conway rule for one cell: popcount of the eight neighbours, then birth on 3 / survive on 2.
module gol_cell_rule (
    input  logic [7:0] nbrs_i,
    input  logic       alive_i,
    output logic       next_o
);
    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(nbrs_i[i]);
        end
        next_o = (count == 4'd3) || ((count == 4'd2) && alive_i);
    end
endmodule

// File: rtl/gol_generation_engine.sv
// Life grid holder: scans one cell per clock into a shadow buffer, then commits it atomically.
module gol_generation_engine
    import gol_pkg::*;
#(
    parameter int unsigned GRID_WIDTH  = gol_pkg::GRID_WIDTH,
    parameter int unsigned GRID_HEIGHT = gol_pkg::GRID_HEIGHT,
    parameter int unsigned TORUS       = 0,
    parameter int unsigned GEN_W       = 16
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    gol_generation_engine_if.slave bus
);
    localparam int unsigned W    = GRID_WIDTH;
    localparam int unsigned H    = GRID_HEIGHT;
    localparam int unsigned N    = W * H;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned XW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned YW   = (H > 1) ? $clog2(H) : 1;
    localparam logic        Wrap = (TORUS != 0);

    gol_state_e       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [N-1:0]     cur_q, cur_d;
    logic [N-1:0]     nxt_q, nxt_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    // Neighbour addressing: row bases are derived from idx by add/subtract only.
    logic [IdxW-1:0] base_c, base_u, base_dn, edit_idx;
    logic [XW-1:0]   xl, xr;
    logic            up_ok, dn_ok, lf_ok, rt_ok, edit_in_range, next_cell;
    logic [7:0]      nbrs;

    function automatic logic pick(input logic [N-1:0] g, input logic [IdxW-1:0] base,
                                  input logic [XW-1:0] col, input logic ok);
        logic [IdxW-1:0] i;
        i = base + IdxW'(col);
        return ok && g[i];
    endfunction

    always_comb begin
        base_c = idx_q - IdxW'(x_q);
        if (y_q == '0) begin
            up_ok  = Wrap;
            base_u = base_c + IdxW'((H - 1) * W);
        end else begin
            up_ok  = 1'b1;
            base_u = base_c - IdxW'(W);
        end
        if (y_q == YW'(H - 1)) begin
            dn_ok   = Wrap;
            base_dn = base_c - IdxW'((H - 1) * W);
        end else begin
            dn_ok   = 1'b1;
            base_dn = base_c + IdxW'(W);
        end
        if (x_q == '0) begin
            lf_ok = Wrap;
            xl    = XW'(W - 1);
        end else begin
            lf_ok = 1'b1;
            xl    = x_q - XW'(1);
        end
        if (x_q == XW'(W - 1)) begin
            rt_ok = Wrap;
            xr    = '0;
        end else begin
            rt_ok = 1'b1;
            xr    = x_q + XW'(1);
        end
        nbrs = {pick(cur_q, base_u,  xl,  up_ok & lf_ok),
                pick(cur_q, base_u,  x_q, up_ok),
                pick(cur_q, base_u,  xr,  up_ok & rt_ok),
                pick(cur_q, base_c,  xl,  lf_ok),
                pick(cur_q, base_c,  xr,  rt_ok),
                pick(cur_q, base_dn, xl,  dn_ok & lf_ok),
                pick(cur_q, base_dn, x_q, dn_ok),
                pick(cur_q, base_dn, xr,  dn_ok & rt_ok)};
    end

    gol_cell_rule u_rule (
        .nbrs_i  (nbrs),
        .alive_i (cur_q[idx_q]),
        .next_o  (next_cell)
    );

    assign edit_in_range = (bus.edit_x < 16'(W)) && (bus.edit_y < 16'(H));
    assign edit_idx      = IdxW'(cell_idx(32'(bus.edit_x), 32'(bus.edit_y), W));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        gen_d   = gen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    cur_d = '0;
                    gen_d = '0;
                end else begin
                    if (bus.edit_en && edit_in_range) begin
                        cur_d[edit_idx] = bus.edit_val;
                    end
                    if (bus.step_req) begin
                        state_d = StScan;
                        idx_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            StScan: begin
                drop_d       = bus.edit_en;
                nxt_d[idx_q] = next_cell;
                if (idx_q == IdxW'(N - 1)) begin
                    state_d = StCommit;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                    if (x_q == XW'(W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            StCommit: begin
                drop_d  = bus.edit_en;
                cur_d   = nxt_q;
                gen_d   = gen_q + GEN_W'(1);
                busy_d  = 1'b0;
                idx_d   = '0;
                x_d     = '0;
                y_d     = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            gen_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.cells      = cur_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.edit_drop  = drop_q;
    assign bus.generation = gen_q;
endmodule

// File: tb/tb_gol_generation_engine.sv
// Scoreboarded bench: a bounded-box engine and a toroidal engine driven by the same stimulus.
module tb_gol_generation_engine;
    import gol_pkg::*;

    localparam int W  = GRID_WIDTH;
    localparam int H  = GRID_HEIGHT;
    localparam int N  = W * H;
    localparam int GW = 16;

    typedef struct packed {
        logic [N-1:0]  cells;
        logic [GW-1:0] gen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_req = 1'b0;
    logic        clear = 1'b0;
    logic        edit_en = 1'b0;
    logic        edit_val = 1'b0;
    logic [15:0] edit_x = '0;
    logic [15:0] edit_y = '0;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  m0 = '0, m1 = '0;
    logic [GW-1:0] mg0 = '0, mg1 = '0;
    exp_t          q0[$], q1[$];

    gol_generation_engine_if #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_W(GW)) bus0 ();
    gol_generation_engine_if #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_W(GW)) bus1 ();

    assign bus0.step_req = step_req;
    assign bus0.clear    = clear;
    assign bus0.edit_en  = edit_en;
    assign bus0.edit_x   = edit_x;
    assign bus0.edit_y   = edit_y;
    assign bus0.edit_val = edit_val;
    assign bus1.step_req = step_req;
    assign bus1.clear    = clear;
    assign bus1.edit_en  = edit_en;
    assign bus1.edit_x   = edit_x;
    assign bus1.edit_y   = edit_y;
    assign bus1.edit_val = edit_val;

    gol_generation_engine #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .TORUS(0), .GEN_W(GW)) dut0 (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus0)
    );

    gol_generation_engine #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .TORUS(1), .GEN_W(GW)) dut1 (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit tor);
        logic [N-1:0] r;
        int n, nx, ny;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        nx = x + dx;
                        ny = y + dy;
                        if (dx == 0 && dy == 0) continue;
                        if (tor) begin
                            nx = (nx + W) % W;
                            ny = (ny + H) % H;
                        end else if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                            continue;
                        end
                        if (g[ny * W + nx]) n++;
                    end
                end
                r[y * W + x] = (n == 3) || (n == 2 && g[y * W + x]);
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] mask(input int x, input int y);
        logic [N-1:0] v;
        v = '0;
        v[cell_idx(x, y, W)] = 1'b1;
        return v;
    endfunction

    task automatic do_edit(input int x, input int y, input logic v);
        @(negedge clk);
        edit_en = 1'b1; edit_x = 16'(x); edit_y = 16'(y); edit_val = v;
        @(negedge clk);
        edit_en = 1'b0;
        if (x < W && y < H) begin
            m0[cell_idx(x, y, W)] = v;
            m1[cell_idx(x, y, W)] = v;
        end
        checks++;
        if (bus0.edit_drop !== 1'b0 || bus1.edit_drop !== 1'b0) begin
            errors++;
            $display("FAIL edit_drop_idle (%0d,%0d): got %b/%b expected 0", x, y,
                     bus0.edit_drop, bus1.edit_drop);
        end
        checks++;
        if (bus0.cells !== m0 || bus1.cells !== m1) begin
            errors++;
            $display("FAIL edit_cells (%0d,%0d): got %h/%h expected %h/%h", x, y,
                     bus0.cells, bus1.cells, m0, m1);
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m0 = '0; m1 = '0; mg0 = '0; mg1 = '0;
        checks++;
        if (bus0.cells !== '0 || bus1.cells !== '0 || bus0.generation !== '0
            || bus1.generation !== '0) begin
            errors++;
            $display("FAIL clear: got cells %h/%h gen %0d/%0d expected 0", bus0.cells,
                     bus1.cells, bus0.generation, bus1.generation);
        end
    endtask

    // One accepted step: push the model's prediction, then watch busy/done and pop on commit.
    task automatic run_step(input bit chk0, input bit chk1, input int inj);
        exp_t e;
        int   cyc, busy0, busy1, done0, done1, dcyc0, dcyc1;
        bit   pend0, pend1;
        m0 = life(m0, 1'b0); mg0 = mg0 + 1'b1;
        m1 = life(m1, 1'b1); mg1 = mg1 + 1'b1;
        q0.push_back(exp_t'{cells: m0, gen: mg0});
        q1.push_back(exp_t'{cells: m1, gen: mg1});
        busy0 = 0; busy1 = 0; done0 = 0; done1 = 0; dcyc0 = 0; dcyc1 = 0;
        pend0 = 1'b0; pend1 = 1'b0;
        @(negedge clk); step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
        cyc = 1;
        repeat (N + 5) begin
            if (pend0) begin
                pend0 = 1'b0;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb0_empty: got done with no expectation queued");
                end else begin
                    e = q0.pop_front();
                    if (chk0) begin
                        checks++;
                        if (bus0.cells !== e.cells || bus0.generation !== e.gen) begin
                            errors++;
                            $display("FAIL sb0_commit: got %h gen %0d expected %h gen %0d",
                                     bus0.cells, bus0.generation, e.cells, e.gen);
                        end
                    end
                end
            end
            if (pend1) begin
                pend1 = 1'b0;
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1_empty: got done with no expectation queued");
                end else begin
                    e = q1.pop_front();
                    if (chk1) begin
                        checks++;
                        if (bus1.cells !== e.cells || bus1.generation !== e.gen) begin
                            errors++;
                            $display("FAIL sb1_commit: got %h gen %0d expected %h gen %0d",
                                     bus1.cells, bus1.generation, e.cells, e.gen);
                        end
                    end
                end
            end
            if (bus0.busy === 1'b1) busy0++;
            if (bus1.busy === 1'b1) busy1++;
            if (bus0.done === 1'b1) begin done0++; dcyc0 = cyc; pend0 = 1'b1; end
            if (bus1.done === 1'b1) begin done1++; dcyc1 = cyc; pend1 = 1'b1; end
            if (inj != 0 && cyc == inj) begin
                edit_en = 1'b1; edit_x = 16'd2; edit_y = 16'd2; edit_val = 1'b1;
            end
            if (inj != 0 && cyc == inj + 1) begin
                edit_en = 1'b0;
                checks++;
                if (bus0.edit_drop !== 1'b1 || bus1.edit_drop !== 1'b1) begin
                    errors++;
                    $display("FAIL edit_drop_busy: got %b/%b expected 1", bus0.edit_drop,
                             bus1.edit_drop);
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (chk0) begin
            checks++;
            if (busy0 != N + 1 || done0 != 1 || dcyc0 != N + 1) begin
                errors++;
                $display("FAIL step_timing0: got busy %0d done %0d at %0d expected %0d/1/%0d",
                         busy0, done0, dcyc0, N + 1, N + 1);
            end
        end
        if (chk1) begin
            checks++;
            if (busy1 != N + 1 || done1 != 1 || dcyc1 != N + 1) begin
                errors++;
                $display("FAIL step_timing1: got busy %0d done %0d at %0d expected %0d/1/%0d",
                         busy1, done1, dcyc1, N + 1, N + 1);
            end
        end
    endtask

    task automatic test_reset();
        int dones;
        dones = 0;
        rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            step_req = ~step_req;
            if (bus0.done === 1'b1 || bus1.done === 1'b1) dones++;
        end
        step_req = 1'b0;
        checks++;
        if (bus0.cells !== '0 || bus1.cells !== '0 || bus0.generation !== '0
            || bus1.generation !== '0 || bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cells %h gen %0d busy %b expected 0",
                     bus0.cells, bus0.generation, bus0.busy);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_done: got %0d done pulses expected 0", dones);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.edit_drop !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy %b done %b drop %b expected 0",
                     bus0.busy, bus0.done, bus0.edit_drop);
        end
    endtask

    task automatic test_edit_range();
        do_edit(12, 3, 1'b1);
        do_edit(3, 12, 1'b1);
    endtask

    task automatic test_blinker();
        logic [N-1:0] vert, horiz;
        vert  = mask(4, 3) | mask(4, 4) | mask(4, 5);
        horiz = mask(3, 4) | mask(4, 4) | mask(5, 4);
        do_edit(4, 3, 1'b1);
        do_edit(4, 4, 1'b1);
        do_edit(4, 5, 1'b1);
        run_step(1'b1, 1'b1, 0);
        checks++;
        if (bus0.cells !== horiz || bus0.generation !== 16'd1) begin
            errors++;
            $display("FAIL blinker_h: got %h gen %0d expected %h gen 1", bus0.cells,
                     bus0.generation, horiz);
        end
        run_step(1'b1, 1'b1, 0);
        checks++;
        if (bus0.cells !== vert || bus0.generation !== 16'd2) begin
            errors++;
            $display("FAIL blinker_v: got %h gen %0d expected %h gen 2", bus0.cells,
                     bus0.generation, vert);
        end
    endtask

    task automatic test_edit_drop();
        run_step(1'b1, 1'b1, 5);
        checks++;
        if (bus0.cells[cell_idx(2, 2, W)] !== 1'b0) begin
            errors++;
            $display("FAIL edit_dropped_cell: got %b expected 0",
                     bus0.cells[cell_idx(2, 2, W)]);
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk); step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (bus0.cells !== m0 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_pre: got %h busy %b expected %h busy 1", bus0.cells,
                     bus0.busy, m0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.cells !== '0 || bus1.cells !== '0 || bus0.busy !== 1'b0
            || bus0.generation !== '0) begin
            errors++;
            $display("FAIL mid_scan_reset: got %h busy %b gen %0d expected 0", bus0.cells,
                     bus0.busy, bus0.generation);
        end
        @(negedge clk); rst_n = 1'b1;
        m0 = '0; m1 = '0; mg0 = '0; mg1 = '0;
        q0.delete(); q1.delete();
        run_step(1'b1, 1'b1, 0);
        checks++;
        if (bus0.cells !== '0 || bus0.generation !== 16'd1) begin
            errors++;
            $display("FAIL empty_step: got %h gen %0d expected 0 gen 1", bus0.cells,
                     bus0.generation);
        end
    endtask

    task automatic test_block();
        logic [N-1:0] blk;
        blk = mask(0, 0) | mask(1, 0) | mask(0, 1) | mask(1, 1);
        do_clear();
        do_edit(0, 0, 1'b1);
        do_edit(1, 0, 1'b1);
        do_edit(0, 1, 1'b1);
        do_edit(1, 1, 1'b1);
        repeat (3) run_step(1'b1, 1'b1, 0);
        checks++;
        if (bus0.cells !== blk || bus0.generation !== 16'd3) begin
            errors++;
            $display("FAIL block: got %h gen %0d expected %h gen 3", bus0.cells,
                     bus0.generation, blk);
        end
    endtask

    task automatic test_glider();
        logic [N-1:0] start;
        start = mask(1, 0) | mask(2, 1) | mask(0, 2) | mask(1, 2) | mask(2, 2);
        do_clear();
        do_edit(1, 0, 1'b1);
        do_edit(2, 1, 1'b1);
        do_edit(0, 2, 1'b1);
        do_edit(1, 2, 1'b1);
        do_edit(2, 2, 1'b1);
        repeat (40) run_step(1'b0, 1'b1, 0);
        checks++;
        if (bus1.cells !== start || bus1.generation !== 16'd40) begin
            errors++;
            $display("FAIL glider_torus: got %h gen %0d expected %h gen 40", bus1.cells,
                     bus1.generation, start);
        end
    endtask

    initial begin
        test_reset();
        test_edit_range();
        test_blinker();
        test_edit_drop();
        test_reset_mid_scan();
        test_block();
        test_glider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
